diff_commit_packer: RTL and testbench

- Sits between the ROB commit ports and the difftest bridge.
- Buffers up to 2 commit records per cycle in a FIFO and drains them to the bridge's 2 commit slots. At most one store and one exception are emitted per drain cycle, because the bridge has a single store port and a single exception port.
- Keeps a shadow GPR file, updated only by drained commits, so the register snapshot always matches the commits the bridge has been shown.

---
 rtl/diff_commit_packer_pkg.sv | 41 ++++
 rtl/diff_commit_packer_if.sv | 30 +++
 rtl/diff_cmt_fifo.sv | 51 +++++
 rtl/diff_commit_packer.sv | 169 ++++++++++++++++
 tb/tb_diff_commit_packer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/diff_commit_packer_pkg.sv
// Shared types for the difftest commit packer: the commit record layout
// and a few small record predicates.
package diff_pkg;
   localparam int NUM_GPR = 32;
   localparam int XLEN    = 64;

   typedef logic [7:0] st_mask_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic            wen;
      logic [4:0]      wdest;
      logic [XLEN-1:0] wdata;
      logic            skip;
      logic            is_tlbfill;
      logic [4:0]      tlbfill_idx;
      logic            is_cnt;
      logic [63:0]     timer64;
      logic            csr_rstat;
      logic [XLEN-1:0] csr_data;
      st_mask_t        st_mask;
      logic [63:0]     st_paddr;
      logic [63:0]     st_vaddr;
      logic [63:0]     st_data;
      logic            excp;
      logic            eret;
      logic [31:0]     intrNo;
      logic [31:0]     cause;
   } cmt_rec_t;

   localparam int REC_W = $bits(cmt_rec_t);

   function automatic logic is_trap(input cmt_rec_t r);
      return r.excp | r.eret;
   endfunction

   function automatic logic has_store(input cmt_rec_t r);
      return r.st_mask != '0;
   endfunction
endpackage

// File: rtl/diff_commit_packer_if.sv
// Commit-side and bridge-side bus of the packer; the packer is the slave,
// the ROB/bridge pair (or a bench) is the master.
interface diff_commit_packer_if;
   import diff_pkg::*;

   logic [1:0] in_valid;
   cmt_rec_t   in_rec_0;
   cmt_rec_t   in_rec_1;
   logic       in_ready;
   logic [1:0] out_valid;
   cmt_rec_t   out_rec_0;
   cmt_rec_t   out_rec_1;
   logic       out_excp;
   st_mask_t   out_st_valid;
   logic [63:0] out_st_paddr;
   logic [63:0] out_st_vaddr;
   logic [63:0] out_st_data;

   modport master (
      output in_valid, in_rec_0, in_rec_1,
      input  in_ready, out_valid, out_rec_0, out_rec_1, out_excp,
             out_st_valid, out_st_paddr, out_st_vaddr, out_st_data
   );

   modport slave (
      input  in_valid, in_rec_0, in_rec_1,
      output in_ready, out_valid, out_rec_0, out_rec_1, out_excp,
             out_st_valid, out_st_paddr, out_st_vaddr, out_st_data
   );
endinterface

// File: rtl/diff_cmt_fifo.sv
// Two-write / two-read circular buffer of commit records. Writes are
// contiguous (port 1 only with port 0); reads pop 0, 1 or 2 from the head.
module diff_cmt_fifo
   import diff_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [1:0]             wr_en,
   input  cmt_rec_t               wr_rec_0,
   input  cmt_rec_t               wr_rec_1,
   input  logic [1:0]             rd_cnt,
   output cmt_rec_t               rd_rec_0,
   output cmt_rec_t               rd_rec_1,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   cmt_rec_t    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(wr_en[0]) + AW'(wr_en[1]);
      rd_ptr_d = rd_ptr_q + AW'(rd_cnt);
      count_d  = count_q + (AW+1)'(wr_en[0]) + (AW+1)'(wr_en[1]) - (AW+1)'(rd_cnt);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset: count gates every read of stale entries.
   always_ff @(posedge clock) begin
      if (wr_en[0]) mem_q[wr_ptr_q] <= wr_rec_0;
      if (wr_en[1]) mem_q[wr_ptr_q + AW'(1)] <= wr_rec_1;
   end

   assign rd_rec_0 = mem_q[rd_ptr_q];
   assign rd_rec_1 = mem_q[rd_ptr_q + AW'(1)];
   assign count    = count_q;
endmodule

// File: rtl/diff_commit_packer.sv
// Buffers ROB commits and drains up to two per cycle to the difftest bridge
// (one store, one trap max), keeping a shadow GPR file. Macro DIFF_PACKER_CHECK_EN adds drop_cnt/sticky_err.
module diff_commit_packer
   import diff_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AFULL = 2
) (
   input  logic                    clock,
   input  logic                    reset_n,
   diff_commit_packer_if.slave     bus,
   output logic [NUM_GPR*XLEN-1:0] gpr_flat,
   output logic                    empty,
   output logic [63:0]             instret
`ifdef DIFF_PACKER_CHECK_EN
   ,
   output logic [15:0]             drop_cnt,
   output logic                    sticky_err
`endif
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  count, free, count_nxt;
   logic [1:0]   want, wr_en, rd_cnt, lost;
   logic         legal, take0, take1;
   cmt_rec_t     h0, h1;

   logic                    in_ready_d, in_ready_q, excp_d, excp_q;
   logic [1:0]              out_valid_d, out_valid_q;
   cmt_rec_t                rec0_d, rec0_q, rec1_d, rec1_q;
   st_mask_t                st_valid_d, st_valid_q;
   logic [63:0]             st_paddr_d, st_paddr_q, st_vaddr_d, st_vaddr_q, st_data_d, st_data_q;
   logic [NUM_GPR*XLEN-1:0] gpr_d, gpr_q;
   logic [63:0]             instret_d, instret_q;

   diff_cmt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock    (clock),
      .reset_n  (reset_n),
      .wr_en    (wr_en),
      .wr_rec_0 (bus.in_rec_0),
      .wr_rec_1 (bus.in_rec_1),
      .rd_cnt   (rd_cnt),
      .rd_rec_0 (h0),
      .rd_rec_1 (h1),
      .count    (count)
   );

   // Enqueue side: 2'b10 is dropped whole; a port without room is dropped.
   always_comb begin
      free      = (AW+1)'(DEPTH) - count;
      legal     = bus.in_valid != 2'b10;
      want      = bus.in_ready ? bus.in_valid : 2'b00;
      wr_en[0]  = want[0] & legal & (free >= (AW+1)'(1));
      wr_en[1]  = want[1] & legal & (free >= (AW+1)'(2));
      lost      = {1'b0, want[0] & ~wr_en[0]} + {1'b0, want[1] & ~wr_en[1]};
   end

   // Drain side: pair the head with head+1 unless that would need a second
   // store or exception port on the bridge.
   always_comb begin
      take0  = count != '0;
      take1  = (count >= (AW+1)'(2)) && !is_trap(h0) && !is_trap(h1)
               && !(has_store(h0) && has_store(h1));
      rd_cnt = {1'b0, take0} + {1'b0, take1};

      count_nxt   = count + (AW+1)'(wr_en[0]) + (AW+1)'(wr_en[1]) - (AW+1)'(rd_cnt);
      in_ready_d  = (DEPTH - int'(count_nxt)) >= (AFULL + 2);

      out_valid_d = {take1, take0};
      rec0_d      = take0 ? h0 : '0;
      rec1_d      = take1 ? h1 : '0;
      excp_d      = take0 && is_trap(h0);

      st_valid_d = '0;
      st_paddr_d = '0;
      st_vaddr_d = '0;
      st_data_d  = '0;
      if (take0 && has_store(h0)) begin
         st_valid_d = h0.st_mask;
         st_paddr_d = h0.st_paddr;
         st_vaddr_d = h0.st_vaddr;
         st_data_d  = h0.st_data;
      end else if (take1 && has_store(h1)) begin
         st_valid_d = h1.st_mask;
         st_paddr_d = h1.st_paddr;
         st_vaddr_d = h1.st_vaddr;
         st_data_d  = h1.st_data;
      end

      // Slot 1 is applied last so it wins on a shared destination.
      gpr_d = gpr_q;
      if (take0 && h0.wen && h0.wdest != '0) gpr_d[int'(h0.wdest)*XLEN +: XLEN] = h0.wdata;
      if (take1 && h1.wen && h1.wdest != '0) gpr_d[int'(h1.wdest)*XLEN +: XLEN] = h1.wdata;

      instret_d = instret_q + 64'(rd_cnt);
   end

   // Output stage: everything the bridge sees loads on the same edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         in_ready_q  <= 1'b1;
         out_valid_q <= '0;
         rec0_q      <= '0;
         rec1_q      <= '0;
         excp_q      <= 1'b0;
         st_valid_q  <= '0;
         st_paddr_q  <= '0;
         st_vaddr_q  <= '0;
         st_data_q   <= '0;
         gpr_q       <= '0;
         instret_q   <= '0;
      end else begin
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         rec0_q      <= rec0_d;
         rec1_q      <= rec1_d;
         excp_q      <= excp_d;
         st_valid_q  <= st_valid_d;
         st_paddr_q  <= st_paddr_d;
         st_vaddr_q  <= st_vaddr_d;
         st_data_q   <= st_data_d;
         gpr_q       <= gpr_d;
         instret_q   <= instret_d;
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_rec_0    = rec0_q;
   assign bus.out_rec_1    = rec1_q;
   assign bus.out_excp     = excp_q;
   assign bus.out_st_valid = st_valid_q;
   assign bus.out_st_paddr = st_paddr_q;
   assign bus.out_st_vaddr = st_vaddr_q;
   assign bus.out_st_data  = st_data_q;
   assign gpr_flat         = gpr_q;
   assign instret          = instret_q;
   assign empty            = count == '0;

`ifdef DIFF_PACKER_CHECK_EN
   logic [15:0] drop_cnt_d, drop_cnt_q;
   logic        sticky_d, sticky_q;
   logic [16:0] drop_sum;

   always_comb begin
      drop_sum   = {1'b0, drop_cnt_q} + 17'(lost);
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      sticky_d   = sticky_q | (lost != 2'd0);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         drop_cnt_q <= '0;
         sticky_q   <= 1'b0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         sticky_q   <= sticky_d;
      end
   end

   assign drop_cnt   = drop_cnt_q;
   assign sticky_err = sticky_q;
`endif

   a_in_valid_legal: assert property (@(posedge clock) disable iff (!reset_n)
      bus.in_valid != 2'b10);
   a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
      !legal || lost == 2'd0);
endmodule

// File: tb/tb_diff_commit_packer.sv
// Directed bench for diff_commit_packer: a queue-based model checked on every
// negedge, plus literal expectations at key points of each scenario.
module tb_diff_commit_packer;
   import diff_pkg::*;

   localparam int DEPTH = 8;
   localparam int AFULL = 2;

   logic clock = 1'b0;
   logic reset_n;
   logic [NUM_GPR*XLEN-1:0] gpr_flat;
   logic empty;
   logic [63:0] instret;
`ifdef DIFF_PACKER_CHECK_EN
   logic [15:0] drop_cnt;
   logic sticky_err;
`endif

   diff_commit_packer_if bus();

   diff_commit_packer #(.DEPTH(DEPTH), .AFULL(AFULL)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .bus      (bus),
      .gpr_flat (gpr_flat),
      .empty    (empty),
      .instret  (instret)
`ifdef DIFF_PACKER_CHECK_EN
      ,
      .drop_cnt   (drop_cnt),
      .sticky_err (sticky_err)
`endif
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   logic ready_low_seen = 1'b0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic chk_rec(input string nm, input cmt_rec_t got, input cmt_rec_t exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got pc=0x%0h cause=0x%0h, expected pc=0x%0h cause=0x%0h (t=%0t)",
                  nm, got.pc, got.cause, exp.pc, exp.cause, $time);
      end
   endtask

   task automatic chk_gpr(input logic [NUM_GPR*XLEN-1:0] got, input logic [NUM_GPR*XLEN-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         for (int i = 0; i < NUM_GPR; i++)
            if (got[i*XLEN +: XLEN] !== exp[i*XLEN +: XLEN]) begin
               $display("FAIL gpr_flat: gpr%0d got 0x%0h, expected 0x%0h (t=%0t)",
                        i, got[i*XLEN +: XLEN], exp[i*XLEN +: XLEN], $time);
               break;
            end
      end
   endtask

   function automatic logic m_trap(input cmt_rec_t r);
      return r.excp || r.eret;
   endfunction

   function automatic logic m_store(input cmt_rec_t r);
      return r.st_mask != 8'h00;
   endfunction

   function automatic cmt_rec_t mk(input logic [63:0] pc, input logic [4:0] wd,
                                   input logic [63:0] wdata, input logic [7:0] mask,
                                   input logic excp, input logic [31:0] cause);
      cmt_rec_t r = '0;
      r.pc      = pc;
      r.instr   = pc[31:0] ^ 32'h0000_0013;
      r.wen     = 1'b1;
      r.wdest   = wd;
      r.wdata   = wdata;
      r.timer64 = pc * 3;
      r.st_mask = mask;
      if (mask != 8'h00) begin
         r.st_paddr = 64'h8000_0000 + pc;
         r.st_vaddr = pc;
         r.st_data  = wdata ^ 64'hA5A5;
      end
      r.excp  = excp;
      r.cause = cause;
      return r;
   endfunction

   // Behavioural model: a queue of buffered records and the expected
   // bridge-side view after the most recent clock edge.
   cmt_rec_t mq[$];
   logic [1:0]  e_valid = '0;
   cmt_rec_t    e_rec0 = '0, e_rec1 = '0;
   logic        e_excp = 1'b0, e_ready = 1'b1, e_empty = 1'b1;
   logic [7:0]  e_st_valid = '0;
   logic [63:0] e_st_paddr = '0, e_st_vaddr = '0, e_st_data = '0, e_instret = '0;
   logic [NUM_GPR*XLEN-1:0] e_gpr = '0;

   always @(negedge clock) begin
      if (!reset_n) begin
         mq.delete();
         e_valid = '0; e_rec0 = '0; e_rec1 = '0; e_excp = 1'b0;
         e_st_valid = '0; e_st_paddr = '0; e_st_vaddr = '0; e_st_data = '0;
         e_gpr = '0; e_instret = '0; e_ready = 1'b1; e_empty = 1'b1;
      end
      chk("out_valid", bus.out_valid, e_valid);
      chk_rec("out_rec_0", bus.out_rec_0, e_rec0);
      chk_rec("out_rec_1", bus.out_rec_1, e_rec1);
      chk("out_excp", bus.out_excp, e_excp);
      chk("out_st_valid", bus.out_st_valid, e_st_valid);
      chk("out_st_paddr", bus.out_st_paddr, e_st_paddr);
      chk("out_st_vaddr", bus.out_st_vaddr, e_st_vaddr);
      chk("out_st_data", bus.out_st_data, e_st_data);
      chk("in_ready", bus.in_ready, e_ready);
      chk("empty", empty, e_empty);
      chk("instret", instret, e_instret);
      chk_gpr(gpr_flat, e_gpr);
`ifdef DIFF_PACKER_CHECK_EN
      chk("drop_cnt", drop_cnt, 0);
      chk("sticky_err", sticky_err, 0);
`endif
      if (reset_n) begin
         automatic logic t0 = mq.size() >= 1;
         automatic logic t1 = mq.size() >= 2 && !m_trap(mq[0]) && !m_trap(mq[1])
                              && !(m_store(mq[0]) && m_store(mq[1]));
         automatic cmt_rec_t drained[$];
         e_valid = {t1, t0};
         e_rec0  = t0 ? mq[0] : '0;
         e_rec1  = t1 ? mq[1] : '0;
         e_excp  = t0 && m_trap(mq[0]);
         if (t0) drained.push_back(mq.pop_front());
         if (t1) drained.push_back(mq.pop_front());
         e_st_valid = '0; e_st_paddr = '0; e_st_vaddr = '0; e_st_data = '0;
         for (int i = drained.size() - 1; i >= 0; i--)
            if (m_store(drained[i])) begin
               e_st_valid = drained[i].st_mask;
               e_st_paddr = drained[i].st_paddr;
               e_st_vaddr = drained[i].st_vaddr;
               e_st_data  = drained[i].st_data;
            end
         foreach (drained[i])
            if (drained[i].wen && drained[i].wdest != 0)
               e_gpr[int'(drained[i].wdest)*XLEN +: XLEN] = drained[i].wdata;
         e_instret = e_instret + 64'(drained.size());
         if (e_ready && bus.in_valid != 2'b10) begin
            if (bus.in_valid[0]) mq.push_back(bus.in_rec_0);
            if (bus.in_valid[1]) mq.push_back(bus.in_rec_1);
         end
         e_ready = (DEPTH - mq.size()) >= (AFULL + 2);
         e_empty = mq.size() == 0;
      end
   end

   // Called at posedge+1; holds the request for exactly one edge.
   task automatic send(input logic [1:0] v, input cmt_rec_t r0, input cmt_rec_t r1);
      int guard = 0;
      while (!bus.in_ready && guard < 100) begin
         ready_low_seen = 1'b1;
         @(posedge clock); #1;
         guard++;
      end
      chk("send_ready_wait", guard < 100, 1);
      bus.in_valid = v;
      bus.in_rec_0 = r0;
      bus.in_rec_1 = r1;
      @(posedge clock); #1;
      bus.in_valid = 2'b00;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 2'b00;
      bus.in_rec_0 = '0;
      bus.in_rec_1 = '0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_empty", empty, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_instret", instret, 0);
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      idle(1);

      // Pair of plain commits
      send(2'b11, mk(64'h1000, 5'd5, 64'h11, 8'h00, 1'b0, 0),
                  mk(64'h1004, 5'd6, 64'h22, 8'h00, 1'b0, 0));
      idle(1);
      chk("t1_out_valid", bus.out_valid, 2'b11);
      chk("t1_gpr5", gpr_flat[5*64 +: 64], 64'h11);
      chk("t1_gpr6", gpr_flat[6*64 +: 64], 64'h22);
      chk("t1_instret", instret, 2);
      idle(3);

      // Two stores in one cycle drain one at a time
      send(2'b11, mk(64'h2000, 5'd7, 64'h77, 8'hFF, 1'b0, 0),
                  mk(64'h2004, 5'd8, 64'h88, 8'h0F, 1'b0, 0));
      idle(1);
      chk("t2a_out_valid", bus.out_valid, 2'b01);
      chk("t2a_st_valid", bus.out_st_valid, 8'hFF);
      idle(1);
      chk("t2b_out_valid", bus.out_valid, 2'b01);
      chk("t2b_st_valid", bus.out_st_valid, 8'h0F);
      idle(3);

      // Exception in slot 1 is delayed to its own drain
      send(2'b11, mk(64'h3000, 5'd9, 64'h99, 8'h00, 1'b0, 0),
                  mk(64'h3004, 5'd0, 64'h0, 8'h00, 1'b1, 32'h8));
      idle(1);
      chk("t3a_out_valid", bus.out_valid, 2'b01);
      chk("t3a_out_excp", bus.out_excp, 0);
      idle(1);
      chk("t3b_out_valid", bus.out_valid, 2'b01);
      chk("t3b_out_excp", bus.out_excp, 1);
      chk("t3b_cause", bus.out_rec_0.cause, 32'h8);
      idle(3);

      // Same destination in both slots; x0 is never written
      send(2'b11, mk(64'h4000, 5'd3, 64'hA, 8'h00, 1'b0, 0),
                  mk(64'h4004, 5'd3, 64'hB, 8'h00, 1'b0, 0));
      idle(1);
      chk("t4_gpr3", gpr_flat[3*64 +: 64], 64'hB);
      send(2'b01, mk(64'h4008, 5'd0, 64'hFF, 8'h00, 1'b0, 0), '0);
      idle(1);
      chk("t4_gpr0", gpr_flat[0 +: 64], 64'h0);
      chk("t4_instret", instret, 9);
      idle(3);

      // Back-to-back store pairs drain at one per cycle and back-pressure
      ready_low_seen = 1'b0;
      for (int i = 0; i < 10; i++)
         send(2'b11, mk(64'h5000 + 64'(16*i), 5'((i % 31) + 1), 64'h5500 + 64'(i), 8'hF0, 1'b0, 0),
                     mk(64'h5008 + 64'(16*i), 5'((i % 30) + 2), 64'h5600 + 64'(i), 8'h0F, 1'b0, 0));
      for (int i = 0; i < 100 && !empty; i++) idle(1);
      idle(1);
      chk("t5_ready_dropped", ready_low_seen, 1);
      chk("t5_empty", empty, 1);
      chk("t5_instret", instret, 29);

      // Reset with four entries buffered
      for (int i = 0; i < 3; i++)
         send(2'b11, mk(64'h6000 + 64'(16*i), 5'd12, 64'h60, 8'h01, 1'b0, 0),
                     mk(64'h6008 + 64'(16*i), 5'd13, 64'h61, 8'h02, 1'b0, 0));
      chk("t6_not_empty", empty, 0);
      reset_n = 1'b0;
      #1;
      chk("t6_empty", empty, 1);
      chk("t6_out_valid", bus.out_valid, 0);
      chk("t6_instret", instret, 0);
      chk("t6_in_ready", bus.in_ready, 1);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      idle(4);
      send(2'b11, mk(64'h7000, 5'd10, 64'h70, 8'h00, 1'b0, 0),
                  mk(64'h7004, 5'd11, 64'h71, 8'h00, 1'b0, 0));
      idle(1);
      chk("t6_post_valid", bus.out_valid, 2'b11);
      chk("t6_post_instret", instret, 2);
      chk("t6_post_gpr12", gpr_flat[12*64 +: 64], 64'h0);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
